// File: rtl/corefifo_rd_ctrl.sv
// corefifo_rd_ctrl: read-domain side of the dual-clock FIFO.
// Owns the binary/Gray read pointer, drives the RAM read port and
// produces registered empty / almost-empty / level / underflow status.
// Build option: define COREFIFO_FWFT_EN for first-word-fall-through;
// without it the block runs in standard (request/1-cycle-latency) mode.
//
// FWFT state table
//   state  | meaning
//   S_IDLE | no head word on the RAM output
//   S_HEAD | head word sitting on the RAM output, dvld=1
module corefifo_rd_ctrl #(
  parameter int ADDRWIDTH     = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 srstn,
  input  logic [ADDRWIDTH:0]   wptr_gray_sync,
  input  logic                 re,
  output logic [ADDRWIDTH:0]   rptr_gray,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic                 ren_mem,
  output logic                 dvld,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rdcnt,
  output logic                 underflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW:0] AE_TH = (PW+1)'(AEMPTY_THRESH);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] rdcnt_q;
  logic [PW-1:0] wbin, lvl_nxt, cnt_nxt;
  logic          pempty_q, pempty_d;
  logic          empty_q, empty_d;
  logic          aempty_q;
  logic          underflow_q, underflow_d;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Synchronized write pointer back to binary for level arithmetic
  always_comb wbin = gray2bin(wptr_gray_sync);

  // Pointer advances on every issued RAM read; level taken from next-state pointer
  always_comb begin
    rbin_d      = ren_mem ? rbin_q + PW'(1) : rbin_q;
    rptr_gray_d = rbin_d ^ (rbin_d >> 1);
    lvl_nxt     = wbin - rbin_d;
    pempty_d    = (lvl_nxt == '0);
  end

`ifdef COREFIFO_FWFT_EN
  typedef enum logic {S_IDLE = 1'b0, S_HEAD = 1'b1} state_e;
  state_e state_q, state_d;
  logic   head_nxt;

  // FSM state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)      state_q <= S_IDLE;
    else if (!srstn) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // FSM next state: fetch whenever idle with data, drop head only when popped dry
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ren_mem) state_d = S_HEAD;
      S_HEAD:  if (re && pempty_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: prefetch when idle, refill on pop, hold RAM output otherwise
  always_comb begin
    ren_mem = 1'b0;
    dvld    = 1'b0;
    case (state_q)
      S_IDLE:  ren_mem = ~pempty_q;
      S_HEAD: begin
        ren_mem = re & ~pempty_q;
        dvld    = 1'b1;
      end
      default: ;
    endcase
    ren_mem = ren_mem & srstn;
  end

  // Status inputs: the head word counts toward the visible level
  always_comb begin
    head_nxt    = (state_d == S_HEAD);
    empty_d     = ~head_nxt;
    cnt_nxt     = lvl_nxt + {{(PW-1){1'b0}}, head_nxt};
    underflow_d = re & ~dvld;
  end
`else
  logic dvld_q;

  // Standard read issue: only on request with data known to be present
  always_comb ren_mem = srstn & re & ~pempty_q;

  // Status inputs straight from the pointer level
  always_comb begin
    empty_d     = pempty_d;
    cnt_nxt     = lvl_nxt;
    underflow_d = re & empty_q;
  end

  // RAM data is valid one cycle after the read is issued
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)      dvld_q <= 1'b0;
    else if (!srstn) dvld_q <= 1'b0;
    else             dvld_q <= ren_mem;
  end

  assign dvld = dvld_q;
`endif

  // Pointer and status registers, all loaded from next-state values
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      pempty_q    <= 1'b1;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      rdcnt_q     <= '0;
      underflow_q <= 1'b0;
    end else if (!srstn) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      pempty_q    <= 1'b1;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      rdcnt_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      pempty_q    <= pempty_d;
      empty_q     <= empty_d;
      aempty_q    <= ({1'b0, cnt_nxt} <= AE_TH);
      rdcnt_q     <= cnt_nxt;
      underflow_q <= underflow_d;
    end
  end

  assign rptr_gray = rptr_gray_q;
  assign raddr     = rbin_q[ADDRWIDTH-1:0];
  assign empty     = empty_q;
  assign aempty    = aempty_q;
  assign rdcnt     = rdcnt_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Bench for corefifo_rd_ctrl. The reference model tracks total words written
// and popped as plain integers; the visible level is their difference.
module tb_corefifo_rd_ctrl;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          srstn = 1'b1;
  logic          re = 1'b0;
  logic [PW-1:0] wptr_gray_sync = '0;
  logic [PW-1:0] rptr_gray;
  logic [AW-1:0] raddr;
  logic          ren_mem, dvld, empty, aempty, underflow;
  logic [PW-1:0] rdcnt;

  int vectors = 0;
  int miscompares = 0;

  int wr_tot = 0;
  int rd_tot = 0;
  int m_level = 0;
  logic          exp_ren, exp_uf, obs_ren;
  logic [AW-1:0] exp_raddr, obs_raddr;

  corefifo_rd_ctrl #(.ADDRWIDTH(AW), .AEMPTY_THRESH(AE_TH)) dut (
    .clk(clk), .arstn(arstn), .srstn(srstn), .wptr_gray_sync(wptr_gray_sync),
    .re(re), .rptr_gray(rptr_gray), .raddr(raddr), .ren_mem(ren_mem),
    .dvld(dvld), .empty(empty), .aempty(aempty), .rdcnt(rdcnt),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  // One read-domain cycle: optional write becomes visible, optional pop request.
  task automatic step(input logic re_v, input logic wr_v);
    @(negedge clk);
    if (wr_v) wr_tot++;
    wptr_gray_sync = to_gray(wr_tot);
    re        = re_v;
    exp_ren   = re_v && (m_level > 0);
    exp_uf    = re_v && (m_level == 0);
    exp_raddr = AW'(rd_tot % DEPTH);
    #1;
    obs_ren   = ren_mem;
    obs_raddr = raddr;
    @(posedge clk);
    #1;
    if (exp_ren) rd_tot++;
    m_level = wr_tot - rd_tot;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #2;
    arstn = 1'b0;
    wptr_gray_sync = '0;
    #1;
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    vectors++; if (aempty !== 1'b1) begin miscompares++; $display("FAIL reset_aempty: got %b want 1", aempty); end
    vectors++; if (rdcnt !== '0) begin miscompares++; $display("FAIL reset_rdcnt: got %0d want 0", rdcnt); end
    vectors++; if (rptr_gray !== '0) begin miscompares++; $display("FAIL reset_rptr: got %0h want 0", rptr_gray); end
    vectors++; if (dvld !== 1'b0) begin miscompares++; $display("FAIL reset_dvld: got %b want 0", dvld); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow); end
    vectors++; if (ren_mem !== 1'b0) begin miscompares++; $display("FAIL reset_ren: got %b want 0", ren_mem); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    wr_tot = 0; rd_tot = 0; m_level = 0;
  endtask

`ifdef COREFIFO_FWFT_EN
  task automatic test_fwft;
    @(negedge clk);
    re = 1'b0; wr_tot = 1; wptr_gray_sync = to_gray(wr_tot);
    #1;
    vectors++; if (ren_mem !== 1'b0) begin miscompares++; $display("FAIL fwft_ren_early: got %b want 0", ren_mem); end
    @(posedge clk); #1;
    vectors++; if (rdcnt !== PW'(1)) begin miscompares++; $display("FAIL fwft_cnt_idle: got %0d want 1", rdcnt); end
    vectors++; if (dvld !== 1'b0) begin miscompares++; $display("FAIL fwft_dvld_idle: got %b want 0", dvld); end
    @(negedge clk); #1;
    vectors++; if (ren_mem !== 1'b1) begin miscompares++; $display("FAIL fwft_ren_pulse: got %b want 1", ren_mem); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++; if (dvld !== 1'b1) begin miscompares++; $display("FAIL fwft_dvld_%0d: got %b want 1", k, dvld); end
      vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fwft_empty_%0d: got %b want 0", k, empty); end
      vectors++; if (rdcnt !== PW'(1)) begin miscompares++; $display("FAIL fwft_cnt_%0d: got %0d want 1", k, rdcnt); end
      @(negedge clk); #1;
      vectors++; if (ren_mem !== 1'b0) begin miscompares++; $display("FAIL fwft_hold_ren_%0d: got %b want 0", k, ren_mem); end
    end
    re = 1'b1;
    @(posedge clk); #1;
    vectors++; if (dvld !== 1'b0) begin miscompares++; $display("FAIL fwft_pop_dvld: got %b want 0", dvld); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fwft_pop_empty: got %b want 1", empty); end
    vectors++; if (rdcnt !== '0) begin miscompares++; $display("FAIL fwft_pop_cnt: got %0d want 0", rdcnt); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL fwft_pop_uf: got %b want 0", underflow); end
    @(negedge clk);
    re = 1'b0;
  endtask
`else
  task automatic test_fill_drain;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    vectors++; if (rdcnt !== PW'(3)) begin miscompares++; $display("FAIL fill_rdcnt: got %0d want 3", rdcnt); end
    vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL fill_empty: got %b want 0", empty); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      vectors++; if (obs_ren !== 1'b1) begin miscompares++; $display("FAIL drain_ren_%0d: got %b want 1", k, obs_ren); end
      vectors++; if (obs_raddr !== AW'(k)) begin miscompares++; $display("FAIL drain_raddr_%0d: got %0d want %0d", k, obs_raddr, k); end
      vectors++; if (dvld !== 1'b1) begin miscompares++; $display("FAIL drain_dvld_%0d: got %b want 1", k, dvld); end
      vectors++; if (rdcnt !== PW'(2 - k)) begin miscompares++; $display("FAIL drain_rdcnt_%0d: got %0d want %0d", k, rdcnt, 2 - k); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_underflow;
    logic [PW-1:0] prev;
    prev = rptr_gray;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0);
      vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_pulse_%0d: got %b want 1", k, underflow); end
      vectors++; if (obs_ren !== 1'b0) begin miscompares++; $display("FAIL uf_ren_%0d: got %b want 0", k, obs_ren); end
      vectors++; if (rptr_gray !== prev) begin miscompares++; $display("FAIL uf_rptr_%0d: got %0h want %0h", k, rptr_gray, prev); end
    end
    step(1'b0, 1'b0);
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_sync_reset;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    @(negedge clk);
    srstn = 1'b0; re = 1'b1; wptr_gray_sync = '0;
    #1;
    vectors++; if (ren_mem !== 1'b0) begin miscompares++; $display("FAIL srst_ren: got %b want 0", ren_mem); end
    @(posedge clk); #1;
    vectors++; if (rptr_gray !== '0) begin miscompares++; $display("FAIL srst_rptr: got %0h want 0", rptr_gray); end
    vectors++; if (rdcnt !== '0) begin miscompares++; $display("FAIL srst_rdcnt: got %0d want 0", rdcnt); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL srst_empty: got %b want 1", empty); end
    vectors++; if (aempty !== 1'b1) begin miscompares++; $display("FAIL srst_aempty: got %b want 1", aempty); end
    vectors++; if (dvld !== 1'b0) begin miscompares++; $display("FAIL srst_dvld: got %b want 0", dvld); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL srst_uf: got %b want 0", underflow); end
    @(negedge clk);
    srstn = 1'b1; re = 1'b0;
    wr_tot = 0; rd_tot = 0; m_level = 0;
  endtask

  task automatic test_wrap;
    logic [PW-1:0] prev;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1);
      prev = rptr_gray;
      step(1'b1, 1'b0);
      vectors++; if ($countones(prev ^ rptr_gray) != 1) begin miscompares++; $display("FAIL wrap_onebit_%0d: got %0h->%0h want one bit change", k, prev, rptr_gray); end
      vectors++; if (rptr_gray[PW-1] !== 1'(((k / DEPTH) % 2))) begin miscompares++; $display("FAIL wrap_msb_%0d: got %b want %0d", k, rptr_gray[PW-1], (k / DEPTH) % 2); end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL wrap_empty: got %b want 1", empty); end
    vectors++; if (rptr_gray !== to_gray(20)) begin miscompares++; $display("FAIL wrap_final: got %0h want %0h", rptr_gray, to_gray(20)); end
  endtask

  task automatic test_simultaneous;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    vectors++; if (rdcnt !== PW'(2)) begin miscompares++; $display("FAIL simul_start: got %0d want 2", rdcnt); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1);
      vectors++; if (rdcnt !== PW'(2)) begin miscompares++; $display("FAIL simul_rdcnt_%0d: got %0d want 2", k, rdcnt); end
      vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL simul_empty_%0d: got %b want 0", k, empty); end
      vectors++; if (dvld !== 1'b1) begin miscompares++; $display("FAIL simul_dvld_%0d: got %b want 1", k, dvld); end
    end
    while (m_level > 0) step(1'b1, 1'b0);
  endtask

  task automatic test_random;
    logic r, w;
    for (int k = 0; k < 300; k++) begin
      if (k < 150) r = ($urandom_range(0, 2) == 0);
      else         r = ($urandom_range(0, 2) != 0);
      w = ($urandom_range(0, 1) == 1) && ((wr_tot - rd_tot) < DEPTH);
      step(r, w);
      vectors++; if (obs_ren !== exp_ren) begin miscompares++; $display("FAIL rnd_ren_%0d: got %b want %b", k, obs_ren, exp_ren); end
      vectors++; if (obs_raddr !== exp_raddr) begin miscompares++; $display("FAIL rnd_raddr_%0d: got %0d want %0d", k, obs_raddr, exp_raddr); end
      vectors++; if (dvld !== exp_ren) begin miscompares++; $display("FAIL rnd_dvld_%0d: got %b want %b", k, dvld, exp_ren); end
      vectors++; if (rdcnt !== PW'(m_level)) begin miscompares++; $display("FAIL rnd_rdcnt_%0d: got %0d want %0d", k, rdcnt, m_level); end
      vectors++; if (empty !== (m_level == 0)) begin miscompares++; $display("FAIL rnd_empty_%0d: got %b want %b", k, empty, m_level == 0); end
      vectors++; if (aempty !== (m_level <= AE_TH)) begin miscompares++; $display("FAIL rnd_aempty_%0d: got %b want %b", k, aempty, m_level <= AE_TH); end
      vectors++; if (underflow !== exp_uf) begin miscompares++; $display("FAIL rnd_uf_%0d: got %b want %b", k, underflow, exp_uf); end
      vectors++; if (rptr_gray !== to_gray(rd_tot)) begin miscompares++; $display("FAIL rnd_rptr_%0d: got %0h want %0h", k, rptr_gray, to_gray(rd_tot)); end
    end
  endtask

  task automatic test_async_mid;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    @(negedge clk);
    #2;
    arstn = 1'b0; re = 1'b0; wptr_gray_sync = '0;
    #1;
    vectors++; if (dvld !== 1'b0) begin miscompares++; $display("FAIL amid_dvld: got %b want 0", dvld); end
    vectors++; if (rptr_gray !== '0) begin miscompares++; $display("FAIL amid_rptr: got %0h want 0", rptr_gray); end
    vectors++; if (raddr !== '0) begin miscompares++; $display("FAIL amid_raddr: got %0d want 0", raddr); end
    vectors++; if (rdcnt !== '0) begin miscompares++; $display("FAIL amid_rdcnt: got %0d want 0", rdcnt); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL amid_empty: got %b want 1", empty); end
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    wr_tot = 0; rd_tot = 0; m_level = 0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef COREFIFO_FWFT_EN
    test_fwft();
`else
    test_fill_drain();
    test_underflow();
    test_sync_reset();
    test_wrap();
    test_simultaneous();
    test_random();
    test_async_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
